// File: rtl/dma_channel_scheduler.sv
// dma_channel_scheduler: four-channel DMA request arbiter and bus-hold sequencer.
// Conditions DREQ/software requests, resolves fixed or rotating priority, runs the
// HRQ/HLDA handshake and drives DACK/Grant/ActiveCh for the channel in service.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no hold requested, waiting for any effective request
// REQ      | HRQ asserted, winner re-resolved each cycle until HLDA
// SERVE    | bus held, Grant/DACK active for ActiveCh
// RELEASE  | HRQ dropped after service, waiting for the CPU to drop HLDA
module dma_channel_scheduler #(
  parameter int NCH = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Disable,
  input  logic             RotPri,
  input  logic             DreqLow,
  input  logic             DackHigh,
  input  logic [NCH-1:0]   DREQ,
  input  logic [NCH-1:0]   Mask,
  input  logic [NCH-1:0]   SwReqSet,
  input  logic [2*NCH-1:0] ServMode,
  input  logic             HLDA,
  input  logic             XferDone,
  input  logic             TC,
  input  logic             EOPn,
  output logic             HRQ,
  output logic [NCH-1:0]   DACK,
  output logic             Grant,
  output logic [1:0]       ActiveCh,
  output logic [NCH-1:0]   PendingReq,
  output logic [NCH-1:0]   TCSet
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVE   = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [NCH-1:0] sw_req_q, sw_req_d;
  logic [1:0]     ptr_q, ptr_d;
  logic [1:0]     active_ch_q, active_ch_d;
  logic           hrq_q, hrq_d;
  logic           grant_q, grant_d;
  logic [NCH-1:0] ack_q, ack_d;
  logic [NCH-1:0] pending_q, pending_d;
  logic [NCH-1:0] tc_set_q, tc_set_d;

  logic [NCH-1:0] active_oh;
  logic [NCH-1:0] next_oh;
  logic [NCH-1:0] raw_req;
  logic [NCH-1:0] req;
  logic [NCH-1:0] sw_clr;
  logic [1:0]     scan_ch;
  logic [1:0]     win_ch;
  logic           win_vld;
  logic [1:0]     cur_mode;
  logic           term_ev;
  logic           serve_exit;

  // Effective request vector; disable keeps only the channel already in service.
  always_comb begin
    active_oh = '0;
    active_oh[active_ch_q] = 1'b1;
    raw_req = ((DREQ ^ {NCH{DreqLow}}) & ~Mask) | sw_req_q;
    if (Disable) begin
      req = (state_q == ST_SERVE) ? (raw_req & active_oh) : '0;
    end else begin
      req = raw_req;
    end
  end

  // Priority resolve: scan upward from ch0 (fixed) or from the rotation pointer.
  always_comb begin
    win_vld = 1'b0;
    win_ch  = 2'd0;
    scan_ch = 2'd0;
    for (int k = 0; k < NCH; k++) begin
      scan_ch = (RotPri ? ptr_q : 2'd0) + k[1:0];
      if (!win_vld && req[scan_ch]) begin
        win_vld = 1'b1;
        win_ch  = scan_ch;
      end
    end
  end

  // Next-state, service termination, software request and registered output logic.
  always_comb begin
    state_d     = state_q;
    active_ch_d = active_ch_q;
    ptr_d       = ptr_q;
    tc_set_d    = '0;
    sw_clr      = '0;
    serve_exit  = 1'b0;
    cur_mode    = ServMode[{active_ch_q, 1'b0} +: 2];
    term_ev     = XferDone & (TC | ~EOPn);

    case (state_q)
      ST_IDLE: begin
        if (|req) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (HLDA && win_vld) begin
          state_d     = ST_SERVE;
          active_ch_d = win_ch;
        end else if (!(|req)) begin
          state_d = HLDA ? ST_RELEASE : ST_IDLE;
        end
      end
      ST_SERVE: begin
        if (!HLDA) begin
          // CPU took the bus back: abandon service without status or rotation.
          state_d = ST_IDLE;
        end else if (XferDone) begin
          if (term_ev) begin
            tc_set_d = active_oh;
            sw_clr   = active_oh;
          end
          case (cur_mode)
            2'b01:   serve_exit = 1'b1;
            2'b00:   serve_exit = term_ev | ~req[active_ch_q];
            default: serve_exit = term_ev;
          endcase
          if (serve_exit) begin
            state_d = ST_RELEASE;
            ptr_d   = active_ch_q + 2'd1;
          end
        end
      end
      ST_RELEASE: begin
        // Going straight to REQ lets HRQ return one cycle after HLDA falls.
        if (!HLDA) state_d = (|req) ? ST_REQ : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    next_oh = '0;
    next_oh[active_ch_d] = 1'b1;

    sw_req_d  = (sw_req_q & ~sw_clr) | SwReqSet;
    hrq_d     = (state_d == ST_REQ) || (state_d == ST_SERVE);
    grant_d   = (state_d == ST_SERVE);
    ack_d     = grant_d ? next_oh : '0;
    pending_d = req;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q     <= ST_IDLE;
      sw_req_q    <= '0;
      ptr_q       <= 2'd0;
      active_ch_q <= 2'd0;
      hrq_q       <= 1'b0;
      grant_q     <= 1'b0;
      ack_q       <= '0;
      pending_q   <= '0;
      tc_set_q    <= '0;
    end else begin
      state_q     <= state_d;
      sw_req_q    <= sw_req_d;
      ptr_q       <= ptr_d;
      active_ch_q <= active_ch_d;
      hrq_q       <= hrq_d;
      grant_q     <= grant_d;
      ack_q       <= ack_d;
      pending_q   <= pending_d;
      tc_set_q    <= tc_set_d;
    end
  end

  assign HRQ        = hrq_q;
  assign Grant      = grant_q;
  assign ActiveCh   = active_ch_q;
  assign PendingReq = pending_q;
  assign TCSet      = tc_set_q;
  assign DACK       = ack_q ^ {NCH{~DackHigh}};

endmodule

// File: tb/tb_dma_channel_scheduler.sv
// tb_dma_channel_scheduler: directed scenarios plus randomized transactions
// checked against a transaction-level priority/termination model.
module tb_dma_channel_scheduler;

  logic       Clock = 1'b0;
  logic       Reset, Disable, RotPri, DreqLow, DackHigh;
  logic [3:0] DREQ, Mask, SwReqSet;
  logic [7:0] ServMode;
  logic       HLDA, XferDone, TC, EOPn;
  logic       HRQ, Grant;
  logic [3:0] DACK, PendingReq, TCSet;
  logic [1:0] ActiveCh;

  int errors = 0;
  int checks = 0;

  dma_channel_scheduler #(.NCH(4)) dut (
    .Clock(Clock), .Reset(Reset), .Disable(Disable), .RotPri(RotPri),
    .DreqLow(DreqLow), .DackHigh(DackHigh), .DREQ(DREQ), .Mask(Mask),
    .SwReqSet(SwReqSet), .ServMode(ServMode), .HLDA(HLDA), .XferDone(XferDone),
    .TC(TC), .EOPn(EOPn), .HRQ(HRQ), .DACK(DACK), .Grant(Grant),
    .ActiveCh(ActiveCh), .PendingReq(PendingReq), .TCSet(TCSet)
  );

  // Free-running system clock.
  always #5 Clock = ~Clock;

  // Guard against a hung run.
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_hrq(input string tag);
    int n;
    n = 0;
    while (HRQ !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_hrq_wait"}, {31'd0, HRQ}, 32'd1);
  endtask

  task automatic pulse_done(input logic tc, input logic eopn);
    XferDone = 1'b1;
    TC       = tc;
    EOPn     = eopn;
    tick();
    XferDone = 1'b0;
    TC       = 1'b0;
    EOPn     = 1'b1;
  endtask

  int         rot_order [5] = '{0, 1, 2, 3, 0};
  logic       dack_ok;
  logic [3:0] r_dreq, r_mask, r_eff, exp_oh, exp_dack;
  logic       r_low, r_dh, tc_last, found;
  logic [7:0] r_modes;
  logic [1:0] mode;
  int         exp_ch, model_ptr, n_xfer, c;

  initial begin
    Reset = 1'b0; Disable = 1'b0; RotPri = 1'b0; DreqLow = 1'b0; DackHigh = 1'b0;
    DREQ = 4'h0; Mask = 4'h0; SwReqSet = 4'h0; ServMode = 8'h55;
    HLDA = 1'b0; XferDone = 1'b0; TC = 1'b0; EOPn = 1'b1;
    tick();
    tick();
    chk("rst_hrq", {31'd0, HRQ}, 32'd0);
    chk("rst_grant", {31'd0, Grant}, 32'd0);
    chk("rst_active", {30'd0, ActiveCh}, 32'd0);
    chk("rst_tcset", {28'd0, TCSet}, 32'd0);
    chk("rst_dack", {28'd0, DACK}, 32'hf);
    chk("rst_pending", {28'd0, PendingReq}, 32'd0);
    Reset = 1'b1;

    // Fixed priority: ch1 then ch3.
    DREQ = 4'b1010;
    tick();
    chk("fix_hrq_rise", {31'd0, HRQ}, 32'd1);
    chk("fix_pending", {28'd0, PendingReq}, 32'ha);
    HLDA = 1'b1;
    tick();
    chk("fix_grant1", {31'd0, Grant}, 32'd1);
    chk("fix_active1", {30'd0, ActiveCh}, 32'd1);
    chk("fix_dack1", {28'd0, DACK}, 32'hd);
    DREQ = 4'b1000;
    pulse_done(1'b0, 1'b1);
    chk("fix_exit_grant", {31'd0, Grant}, 32'd0);
    chk("fix_exit_hrq", {31'd0, HRQ}, 32'd0);
    chk("fix_exit_dack", {28'd0, DACK}, 32'hf);
    chk("fix_exit_tcset", {28'd0, TCSet}, 32'd0);
    tick();
    chk("fix_release_hrq", {31'd0, HRQ}, 32'd0);
    HLDA = 1'b0;
    tick();
    chk("fix_rerequest", {31'd0, HRQ}, 32'd1);
    HLDA = 1'b1;
    tick();
    chk("fix_active3", {30'd0, ActiveCh}, 32'd3);
    chk("fix_dack3", {28'd0, DACK}, 32'h7);
    DREQ = 4'b0000;
    pulse_done(1'b0, 1'b1);
    chk("fix_exit3_grant", {31'd0, Grant}, 32'd0);
    HLDA = 1'b0;
    tick();

    // Rotating priority with all channels requesting.
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    RotPri = 1'b1;
    DREQ = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_hrq("rot");
      HLDA = 1'b1;
      tick();
      chk("rot_active", {30'd0, ActiveCh}, rot_order[i]);
      pulse_done(1'b0, 1'b1);
      chk("rot_tcset", {28'd0, TCSet}, 32'd0);
      HLDA = 1'b0;
    end
    DREQ = 4'b0000;
    RotPri = 1'b0;
    tick();

    // Block mode on ch2: three transfers, TC on the third.
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    ServMode = 8'h65;
    DREQ = 4'b0100;
    wait_hrq("blk");
    HLDA = 1'b1;
    tick();
    chk("blk_active", {30'd0, ActiveCh}, 32'd2);
    dack_ok = 1'b1;
    for (int x = 1; x <= 3; x++) begin
      repeat (3) begin
        tick();
        if (DACK !== 4'b1011) dack_ok = 1'b0;
      end
      pulse_done(x == 3, 1'b1);
      if (x < 3) begin
        if (DACK !== 4'b1011) dack_ok = 1'b0;
        chk("blk_mid_grant", {31'd0, Grant}, 32'd1);
        chk("blk_mid_tcset", {28'd0, TCSet}, 32'd0);
      end
    end
    chk("blk_dack_cont", {31'd0, dack_ok}, 32'd1);
    chk("blk_tcset", {28'd0, TCSet}, 32'h4);
    chk("blk_hrq_fall", {31'd0, HRQ}, 32'd0);
    tick();
    chk("blk_tcset_once", {28'd0, TCSet}, 32'd0);
    DREQ = 4'b0000;
    HLDA = 1'b0;
    tick();

    // Demand mode on ch0: request drops before the second transfer.
    ServMode = 8'h54;
    DREQ = 4'b0001;
    wait_hrq("dem");
    HLDA = 1'b1;
    tick();
    chk("dem_active", {30'd0, ActiveCh}, 32'd0);
    pulse_done(1'b0, 1'b1);
    chk("dem_stay", {31'd0, Grant}, 32'd1);
    DREQ = 4'b0000;
    tick();
    pulse_done(1'b0, 1'b1);
    chk("dem_exit", {31'd0, Grant}, 32'd0);
    chk("dem_no_tcset", {28'd0, TCSet}, 32'd0);
    chk("dem_hrq", {31'd0, HRQ}, 32'd0);
    HLDA = 1'b0;
    tick();
    DREQ = 4'b0001;
    wait_hrq("dem_eop");
    HLDA = 1'b1;
    tick();
    pulse_done(1'b0, 1'b0);
    chk("dem_eop_exit", {31'd0, Grant}, 32'd0);
    chk("dem_eop_tcset", {28'd0, TCSet}, 32'h1);
    DREQ = 4'b0000;
    HLDA = 1'b0;
    tick();

    // Polarity, masking and software request.
    Reset = 1'b0;
    DreqLow = 1'b1;
    DackHigh = 1'b1;
    DREQ = 4'b1110;
    Mask = 4'b0000;
    ServMode = 8'h55;
    tick();
    chk("pol_rst_dack", {28'd0, DACK}, 32'h0);
    Reset = 1'b1;
    wait_hrq("pol");
    chk("pol_pending", {28'd0, PendingReq}, 32'h1);
    HLDA = 1'b1;
    tick();
    chk("pol_dack", {28'd0, DACK}, 32'h1);
    chk("pol_active", {30'd0, ActiveCh}, 32'd0);
    pulse_done(1'b0, 1'b1);
    HLDA = 1'b0;
    Mask = 4'b0001;
    repeat (4) tick();
    chk("pol_mask_hrq", {31'd0, HRQ}, 32'd0);
    chk("pol_mask_pending", {28'd0, PendingReq}, 32'd0);
    SwReqSet = 4'b0001;
    tick();
    SwReqSet = 4'b0000;
    wait_hrq("sw");
    chk("sw_pending", {28'd0, PendingReq}, 32'h1);
    HLDA = 1'b1;
    tick();
    chk("sw_dack", {28'd0, DACK}, 32'h1);
    pulse_done(1'b1, 1'b1);
    chk("sw_tcset", {28'd0, TCSet}, 32'h1);
    HLDA = 1'b0;
    repeat (3) tick();
    chk("sw_cleared_hrq", {31'd0, HRQ}, 32'd0);
    chk("sw_cleared_pending", {28'd0, PendingReq}, 32'd0);
    DreqLow = 1'b0;
    DackHigh = 1'b0;
    Mask = 4'b0000;
    DREQ = 4'b0000;
    tick();

    // Controller disable blocks new arbitration.
    Disable = 1'b1;
    DREQ = 4'b0001;
    repeat (3) tick();
    chk("dis_hrq", {31'd0, HRQ}, 32'd0);
    chk("dis_pending", {28'd0, PendingReq}, 32'd0);
    Disable = 1'b0;
    DREQ = 4'b0000;
    tick();

    // Abort by HLDA drop, then reset during REQ and SERVE.
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    RotPri = 1'b1;
    DREQ = 4'b1111;
    wait_hrq("abt0");
    HLDA = 1'b1;
    tick();
    chk("abt_active0", {30'd0, ActiveCh}, 32'd0);
    pulse_done(1'b0, 1'b1);
    HLDA = 1'b0;
    wait_hrq("abt1");
    HLDA = 1'b1;
    tick();
    chk("abt_active1", {30'd0, ActiveCh}, 32'd1);
    HLDA = 1'b0;
    XferDone = 1'b1;
    TC = 1'b1;
    tick();
    XferDone = 1'b0;
    TC = 1'b0;
    chk("abt_grant", {31'd0, Grant}, 32'd0);
    chk("abt_dack", {28'd0, DACK}, 32'hf);
    chk("abt_tcset", {28'd0, TCSet}, 32'd0);
    chk("abt_hrq", {31'd0, HRQ}, 32'd0);
    wait_hrq("abt_retry");
    HLDA = 1'b1;
    tick();
    chk("abt_ptr_kept", {30'd0, ActiveCh}, 32'd1);
    pulse_done(1'b0, 1'b1);
    HLDA = 1'b0;
    wait_hrq("rst_req");
    Reset = 1'b0;
    tick();
    chk("rstreq_hrq", {31'd0, HRQ}, 32'd0);
    chk("rstreq_dack", {28'd0, DACK}, 32'hf);
    chk("rstreq_active", {30'd0, ActiveCh}, 32'd0);
    Reset = 1'b1;
    wait_hrq("rst_serve");
    HLDA = 1'b1;
    tick();
    chk("rstserve_grant_pre", {31'd0, Grant}, 32'd1);
    Reset = 1'b0;
    tick();
    chk("rstserve_grant", {31'd0, Grant}, 32'd0);
    chk("rstserve_hrq", {31'd0, HRQ}, 32'd0);
    chk("rstserve_dack", {28'd0, DACK}, 32'hf);
    HLDA = 1'b0;
    DREQ = 4'b0000;
    tick();

    // Randomized transactions under rotating priority against a transaction model.
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    RotPri = 1'b1;
    model_ptr = 0;
    for (int t = 0; t < 40; t++) begin
      do begin
        r_dreq = 4'($urandom_range(0, 15));
        r_mask = 4'($urandom_range(0, 15));
        r_low  = 1'($urandom_range(0, 1));
        r_eff  = (r_dreq ^ {4{r_low}}) & ~r_mask;
      end while (r_eff == 4'd0);
      r_dh    = 1'($urandom_range(0, 1));
      r_modes = 8'($urandom_range(0, 255));
      found = 1'b0;
      exp_ch = 0;
      for (int k = 0; k < 4; k++) begin
        c = (model_ptr + k) % 4;
        if (!found && r_eff[c]) begin
          found = 1'b1;
          exp_ch = c;
        end
      end
      mode = r_modes[2*exp_ch +: 2];
      if (mode == 2'b01) begin
        n_xfer  = 1;
        tc_last = 1'($urandom_range(0, 1));
      end else begin
        n_xfer  = $urandom_range(1, 3);
        tc_last = 1'b1;
      end
      exp_oh   = 4'b0001 << exp_ch;
      exp_dack = r_dh ? exp_oh : ~exp_oh;

      DREQ = r_dreq;
      Mask = r_mask;
      DreqLow = r_low;
      DackHigh = r_dh;
      ServMode = r_modes;
      HLDA = 1'b0;
      wait_hrq("rnd");
      chk("rnd_pending", {28'd0, PendingReq}, {28'd0, r_eff});
      HLDA = 1'b1;
      tick();
      chk("rnd_active", {30'd0, ActiveCh}, exp_ch);
      chk("rnd_dack", {28'd0, DACK}, {28'd0, exp_dack});
      for (int x = 1; x <= n_xfer; x++) begin
        pulse_done((x == n_xfer) ? tc_last : 1'b0, 1'b1);
        if (x < n_xfer) begin
          chk("rnd_mid_grant", {31'd0, Grant}, 32'd1);
        end else begin
          chk("rnd_exit_grant", {31'd0, Grant}, 32'd0);
          chk("rnd_exit_tcset", {28'd0, TCSet}, tc_last ? {28'd0, exp_oh} : 32'd0);
        end
      end
      model_ptr = (exp_ch + 1) % 4;
      HLDA = 1'b0;
    end
    DREQ = 4'b0000;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
